// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC/IR, fetches over a req/ready
// handshake with timeout, decodes fields and computes the next PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic        select_jal,
  input  logic        select_jalr,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir_pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        ir_valid,
  output logic        busy,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_pc_q;
  logic [31:0] ir_q;
  logic [31:0] addr_q;
  logic [31:0] cnt_q;
  logic        fault_q;
  logic [31:0] redir_d;
  logic        hs;
  logic        to_hit;

  assign hs     = (state_q == REQ) && imem_ready;
  assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // Redirect target; jalr has priority over jal/branch.
  always_comb begin
    redir_d = ir_pc_q + 32'd4;
    if (select_jalr)
      redir_d = (rs1_val + imm) & 32'hFFFF_FFFE;
    else if (select_jal || branch_taken)
      redir_d = ir_pc_q + imm;
  end

  // Fetch FSM plus PC/IR state; pc_load overrides handshake PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_pc_q <= RESET_PC;
      ir_q    <= NOP_INSTR;
      addr_q  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fetch_req) begin
            if (pc_q[1:0] == 2'b00) begin
              addr_q  <= pc_q;
              cnt_q   <= '0;
              state_q <= REQ;
            end else begin
              ir_q    <= NOP_INSTR;
              ir_pc_q <= pc_q;
              fault_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        REQ: begin
          if (imem_ready) begin
            ir_q    <= imem_rdata;
            ir_pc_q <= addr_q;
            fault_q <= 1'b0;
            state_q <= DONE;
          end else if (to_hit) begin
            ir_q    <= NOP_INSTR;
            fault_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (pc_load)
        pc_q <= redir_d;
      else if (hs)
        pc_q <= addr_q + 32'd4;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = addr_q;
  assign ir_valid    = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign fetch_fault = fault_q;
  assign pc          = pc_q;
  assign ir_pc       = ir_pc_q;
  assign ir          = ir_q;
  assign pc_plus4    = ir_pc_q + 32'd4;
  assign opcode      = ir_q[6:0];
  assign rd          = ir_q[11:7];
  assign funct3      = ir_q[14:12];
  assign rs1         = ir_q[19:15];
  assign rs2         = ir_q[24:20];
  assign funct7      = ir_q[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random fetches/redirects against
// an address-level model; a monitor checks every ir_valid pulse.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, pc_load, select_jal, select_jalr, branch_taken;
  logic [31:0] imm, rs1_val;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc, ir_pc, pc_plus4, ir;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        ir_valid, busy, fetch_fault;

  fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
    .select_jal(select_jal), .select_jalr(select_jalr),
    .branch_taken(branch_taken), .imm(imm), .rs1_val(rs1_val),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc(pc), .ir_pc(ir_pc), .pc_plus4(pc_plus4),
    .ir(ir), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .ir_valid(ir_valid), .busy(busy),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] irpc;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  typedef struct {
    int          len;
    logic [31:0] addr;
  } req_t;

  exp_t        scq[$];
  req_t        reqq[$];
  logic [31:0] pcq[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] mpc, mirpc;
  int          cur_lat = 0;
  logic        ld_seen;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Memory responder: ready after cur_lat wait cycles.
  initial begin : mem
    int cnt;
    logic [31:0] a0;
    req_t r;
    cnt = 0;
    a0 = '0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (cnt == 0) a0 = imem_addr;
        else chk("addr_stable", imem_addr, a0);
        if (cnt == cur_lat) begin
          imem_ready = 1'b1;
          imem_rdata = memf(imem_addr);
        end else begin
          imem_ready = 1'b0;
          imem_rdata = $urandom;
        end
        cnt++;
      end else begin
        imem_ready = 1'b0;
        if (cnt != 0) begin
          if (reqq.size() == 0) begin
            chk("unexpected_req", 32'(cnt), 32'h0);
          end else begin
            r = reqq.pop_front();
            chk("req_len", 32'(cnt), 32'(r.len));
            chk("req_addr", a0, r.addr);
          end
          cnt = 0;
        end
      end
    end
  end

  always @(posedge clk or posedge reset)
    if (reset) ld_seen <= 1'b0;
    else ld_seen <= pc_load;

  // Monitor: compare each IR delivery and each redirect.
  initial begin : mon
    exp_t e;
    logic [31:0] p;
    forever begin
      @(negedge clk);
      if (ir_valid) begin
        if (scq.size() == 0) begin
          chk("unexpected_ir_valid", 32'h1, 32'h0);
        end else begin
          e = scq.pop_front();
          chk("ir", ir, e.ir);
          chk("ir_pc", ir_pc, e.irpc);
          chk("pc_after_fetch", pc, e.pc);
          chk("fault", {31'h0, fetch_fault}, {31'h0, e.fault});
          chk("opcode", {25'h0, opcode}, {25'h0, e.ir[6:0]});
          chk("rd", {27'h0, rd}, {27'h0, e.ir[11:7]});
          chk("rs1", {27'h0, rs1}, {27'h0, e.ir[19:15]});
          chk("rs2", {27'h0, rs2}, {27'h0, e.ir[24:20]});
          chk("funct3", {29'h0, funct3}, {29'h0, e.ir[14:12]});
          chk("funct7", {25'h0, funct7}, {25'h0, e.ir[31:25]});
          chk("pc_plus4", pc_plus4, e.irpc + 32'd4);
        end
      end
      if (ld_seen) begin
        if (pcq.size() == 0) begin
          chk("unexpected_load", 32'h1, 32'h0);
        end else begin
          p = pcq.pop_front();
          chk("pc_redirect", pc, p);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mpc = 32'h0;
    mirpc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_fetch(input int lat);
    exp_t e;
    int k, kexp;
    bit seen;
    cur_lat = lat;
    if (mpc[1:0] != 2'b00) begin
      e = '{NOP, mpc, mpc, 1'b1};
      kexp = 1;
    end else if (lat >= TO) begin
      e = '{NOP, mirpc, mpc, 1'b1};
      reqq.push_back('{TO, mpc});
      kexp = TO + 1;
    end else begin
      e = '{memf(mpc), mpc, mpc + 32'd4, 1'b0};
      reqq.push_back('{lat + 1, mpc});
      kexp = lat + 2;
    end
    mirpc = e.irpc;
    mpc = e.pc;
    scq.push_back(e);
    @(negedge clk);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    k = 1;
    seen = ir_valid;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      seen = ir_valid;
    end
    chk("fetch_latency", seen ? 32'(k) : 32'hFFFF_FFFF, 32'(kexp));
    @(negedge clk);
    chk("valid_pulse", {31'h0, ir_valid}, 32'h0);
  endtask

  task automatic do_redir(input logic jal, input logic jalr,
                          input logic br, input logic [31:0] im,
                          input logic [31:0] r1);
    logic [31:0] t;
    if (jalr) t = (r1 + im) & ~32'h1;
    else if (jal || br) t = mirpc + im;
    else t = mirpc + 32'd4;
    pcq.push_back(t);
    mpc = t;
    @(negedge clk);
    pc_load = 1'b1;
    select_jal = jal;
    select_jalr = jalr;
    branch_taken = br;
    imm = im;
    rs1_val = r1;
    @(negedge clk);
    pc_load = 1'b0;
    select_jal = 1'b0;
    select_jalr = 1'b0;
    branch_taken = 1'b0;
    chk("link_pc_plus4", pc_plus4, mirpc + 32'd4);
  endtask

  initial begin : stim
    logic [31:0] ri;
    int r;
    reset = 1'b1;
    fetch_req = 1'b0;
    pc_load = 1'b0;
    select_jal = 1'b0;
    select_jalr = 1'b0;
    branch_taken = 1'b0;
    imm = '0;
    rs1_val = '0;
    mpc = 32'h0;
    mirpc = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir_pc", ir_pc, 32'h0);
    chk("rst_ir", ir, NOP);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, ir_valid}, 32'h0);
    chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);

    do_fetch(0);
    do_fetch(0);
    do_fetch(4);
    do_fetch(20);
    do_fetch(1);
    do_fetch(14);
    do_fetch(15);
    do_fetch(0);
    do_redir(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0);
    do_redir(1'b0, 1'b1, 1'b0, 32'h4, 32'h101);
    do_redir(1'b1, 1'b1, 1'b0, 32'h8, 32'h200);

    do_reset();
    do_fetch(0);
    do_redir(1'b1, 1'b0, 1'b0, 32'h6, 32'h0);
    do_fetch(0);
    do_fetch(2);

    do_reset();
    cur_lat = 1;
    reqq.push_back('{1, 32'h0});
    @(negedge clk);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_req", {31'h0, imem_req}, 32'h0);
    chk("rst_mid_pc", pc, 32'h0);
    chk("rst_mid_ir", ir, NOP);
    chk("rst_mid_valid", {31'h0, ir_valid}, 32'h0);
    mpc = 32'h0;
    mirpc = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_idle", {31'h0, busy}, 32'h0);

    repeat (250) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        if ($urandom_range(0, 9) == 0)
          do_fetch(14 + $urandom_range(0, 4));
        else
          do_fetch($urandom_range(0, 5));
      end else begin
        ri = $urandom;
        if ($urandom_range(0, 3) != 0) ri[1:0] = 2'b00;
        do_redir(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ri,
                 ($urandom_range(0, 1) == 1) ? 32'($urandom) & ~32'h3
                                             : 32'($urandom));
      end
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(scq.size()), 32'h0);
    chk("req_q_empty", 32'(reqq.size()), 32'h0);
    chk("pc_q_empty", 32'(pcq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
